// File: rtl/vsync_frame_timer.sv
// vsync_frame_timer
// Vertical timing stage of the VGA video timer. Counts rising edges of the
// horizontal stage's LineEnd indication. From that count it produces the line
// coordinate, the active-low vsync, the vertical active-video flag and a
// one-clock frame-end strobe. Timing parameters are shadowed and reloaded only
// at the frame wrap, so a change made mid-frame never tears the current frame.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   LineEnd      line-end level from the horizontal stage; each rising edge is one line
//   ActiveVideo  vertical active lines      (sampled at frame wrap)
//   FrontPorch   vertical front porch lines (sampled at frame wrap)
//   SynchPulse   vertical sync lines        (sampled at frame wrap)
//   BackPorch    vertical back porch lines  (sampled at frame wrap)
//   yposition    current line number
//   vsync        active-low vertical sync
//   vActive      high while yposition < shadow ActiveVideo
//   FrameEnd     one-clock strobe on the edge where yposition returns to 0
//   FrameCount   frames completed, modulo 2^framebits
//   ParamError   sticky: a sampled parameter set was rejected
module vsync_frame_timer #(
  parameter int yresolution = 10,
  parameter int framebits   = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   LineEnd,
  input  logic [yresolution-1:0] ActiveVideo,
  input  logic [yresolution-1:0] FrontPorch,
  input  logic [yresolution-1:0] SynchPulse,
  input  logic [yresolution-1:0] BackPorch,
  output logic [yresolution-1:0] yposition,
  output logic                   vsync,
  output logic                   vActive,
  output logic                   FrameEnd,
  output logic [framebits-1:0]   FrameCount,
  output logic                   ParamError
);

  localparam int SW = yresolution + 2;

  typedef logic [yresolution-1:0] line_t;
  typedef logic [SW-1:0]          sum_t;
  typedef logic [framebits-1:0]   frame_t;

  localparam line_t A_RST     = line_t'(480);
  localparam line_t F_RST     = line_t'(10);
  localparam line_t S_RST     = line_t'(2);
  localparam line_t B_RST     = line_t'(33);
  localparam sum_t  MAX_LINES = sum_t'((64'd1 << yresolution) - 64'd1);

  logic   line_end_q,    line_end_d;
  line_t  ycount_q,      ycount_d;
  line_t  a_q,           a_d;
  line_t  f_q,           f_d;
  line_t  s_q,           s_d;
  line_t  b_q,           b_d;
  logic   vsync_q,       vsync_d;
  logic   vactive_q,     vactive_d;
  logic   frame_end_q,   frame_end_d;
  frame_t frame_count_q, frame_count_d;
  logic   param_error_q, param_error_d;

  logic tick;
  logic wrap;
  logic params_ok;
  sum_t end_sum;
  sum_t in_sum;
  sum_t vs_start;
  sum_t vs_stop;
  sum_t y_ext;

  always_comb begin
    tick = LineEnd & ~line_end_q;

    // All sums are kept two bits wider than a line number so that an
    // oversized input set is detected instead of silently wrapping.
    end_sum = {2'b00, a_q} + {2'b00, f_q} + {2'b00, s_q} + {2'b00, b_q};
    in_sum  = {2'b00, ActiveVideo} + {2'b00, FrontPorch}
            + {2'b00, SynchPulse} + {2'b00, BackPorch};

    wrap      = tick && ({2'b00, ycount_q} == end_sum);
    params_ok = (ActiveVideo != '0) && (SynchPulse != '0) && (in_sum <= MAX_LINES);

    line_end_d    = LineEnd;
    ycount_d      = ycount_q;
    a_d           = a_q;
    f_d           = f_q;
    s_d           = s_q;
    b_d           = b_q;
    frame_end_d   = 1'b0;
    frame_count_d = frame_count_q;
    param_error_d = param_error_q;

    if (tick) begin
      if (wrap) ycount_d = '0;
      else      ycount_d = ycount_q + line_t'(1);
    end

    if (wrap) begin
      frame_end_d   = 1'b1;
      frame_count_d = frame_count_q + frame_t'(1);
      if (params_ok) begin
        a_d = ActiveVideo;
        f_d = FrontPorch;
        s_d = SynchPulse;
        b_d = BackPorch;
      end else begin
        param_error_d = 1'b1;
      end
    end

    // Outputs are decoded from next-state count and shadows so they are
    // registered yet change on the same edge as yposition.
    vs_start  = {2'b00, a_d} + {2'b00, f_d};
    vs_stop   = vs_start + {2'b00, s_d};
    y_ext     = {2'b00, ycount_d};
    vsync_d   = !((y_ext >= vs_start) && (y_ext < vs_stop));
    vactive_d = (ycount_d < a_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // Starting high means a LineEnd already asserted at release is not a line.
      line_end_q    <= 1'b1;
      ycount_q      <= '0;
      a_q           <= A_RST;
      f_q           <= F_RST;
      s_q           <= S_RST;
      b_q           <= B_RST;
      vsync_q       <= 1'b1;
      vactive_q     <= 1'b1;
      frame_end_q   <= 1'b0;
      frame_count_q <= '0;
      param_error_q <= 1'b0;
    end else begin
      line_end_q    <= line_end_d;
      ycount_q      <= ycount_d;
      a_q           <= a_d;
      f_q           <= f_d;
      s_q           <= s_d;
      b_q           <= b_d;
      vsync_q       <= vsync_d;
      vactive_q     <= vactive_d;
      frame_end_q   <= frame_end_d;
      frame_count_q <= frame_count_d;
      param_error_q <= param_error_d;
    end
  end

  assign yposition  = ycount_q;
  assign vsync      = vsync_q;
  assign vActive    = vactive_q;
  assign FrameEnd   = frame_end_q;
  assign FrameCount = frame_count_q;
  assign ParamError = param_error_q;

endmodule

// File: tb/tb_vsync_frame_timer.sv
// Testbench for vsync_frame_timer (yresolution=10, framebits=2).
module tb_vsync_frame_timer;

  logic       clock;
  logic       reset;
  logic       LineEnd;
  logic [9:0] ActiveVideo;
  logic [9:0] FrontPorch;
  logic [9:0] SynchPulse;
  logic [9:0] BackPorch;
  logic [9:0] yposition;
  logic       vsync;
  logic       vActive;
  logic       FrameEnd;
  logic [1:0] FrameCount;
  logic       ParamError;

  int errors = 0;
  int checks = 0;
  int exp_fc = 0;

  vsync_frame_timer #(.yresolution(10), .framebits(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .LineEnd    (LineEnd),
    .ActiveVideo(ActiveVideo),
    .FrontPorch (FrontPorch),
    .SynchPulse (SynchPulse),
    .BackPorch  (BackPorch),
    .yposition  (yposition),
    .vsync      (vsync),
    .vActive    (vActive),
    .FrameEnd   (FrameEnd),
    .FrameCount (FrameCount),
    .ParamError (ParamError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int a, f, s, b;      // inputs presented at the wrap
    int ea, ef, es, eb;  // expected shadows for the following frame
    int eperr;           // expected ParamError after the wrap
  } rec_t;

  rec_t recs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_inputs(input int a, input int f, input int s, input int b);
    ActiveVideo = 10'(a);
    FrontPorch  = 10'(f);
    SynchPulse  = 10'(s);
    BackPorch   = 10'(b);
  endtask

  // One-clock LineEnd pulse; returns on the negedge after the counting edge.
  task automatic tick_line();
    @(negedge clock);
    LineEnd = 1'b1;
    @(negedge clock);
    LineEnd = 1'b0;
  endtask

  // Walks lines 1..a+f+s+b of a frame; optionally changes inputs at mid_y.
  task automatic walk_frame(input int a, input int f, input int s, input int b,
                            input int mid_y);
    int last;
    bit vs_exp;
    last = a + f + s + b;
    for (int y = 1; y <= last; y++) begin
      tick_line();
      vs_exp = !((y >= a + f) && (y < a + f + s));
      check("walk_y", int'(yposition), y);
      check("walk_vsync", int'(vsync), int'(vs_exp));
      check("walk_vactive", int'(vActive), (y < a) ? 1 : 0);
      check("walk_frameend", int'(FrameEnd), 0);
      if (y == mid_y) set_inputs(4, 1, 1, 2);
    end
  endtask

  task automatic do_wrap(input int eperr);
    tick_line();
    exp_fc = (exp_fc + 1) % 4;
    check("wrap_y", int'(yposition), 0);
    check("wrap_frameend", int'(FrameEnd), 1);
    check("wrap_framecount", int'(FrameCount), exp_fc);
    check("wrap_paramerror", int'(ParamError), eperr);
    check("wrap_vactive", int'(vActive), 1);
    @(negedge clock);
    check("frameend_one_clk", int'(FrameEnd), 0);
  endtask

  initial begin
    recs[0] = '{a:4,    f:1,   s:1,   b:2,   ea:4,    ef:1, es:1, eb:2, eperr:0};
    recs[1] = '{a:0,    f:1,   s:1,   b:2,   ea:4,    ef:1, es:1, eb:2, eperr:1};
    recs[2] = '{a:4,    f:1,   s:0,   b:2,   ea:4,    ef:1, es:1, eb:2, eperr:1};
    recs[3] = '{a:500,  f:300, s:200, b:100, ea:4,    ef:1, es:1, eb:2, eperr:1};
    recs[4] = '{a:3,    f:2,   s:2,   b:1,   ea:3,    ef:2, es:2, eb:1, eperr:1};
    recs[5] = '{a:1020, f:0,   s:1,   b:2,   ea:1020, ef:0, es:1, eb:2, eperr:1};
    recs[6] = '{a:1020, f:0,   s:2,   b:2,   ea:1020, ef:0, es:1, eb:2, eperr:1};
    recs[7] = '{a:4,    f:1,   s:1,   b:2,   ea:4,    ef:1, es:1, eb:2, eperr:1};

    reset   = 1'b0;
    LineEnd = 1'b0;
    set_inputs(480, 10, 2, 33);
    #12;
    check("rst_y", int'(yposition), 0);
    check("rst_vsync", int'(vsync), 1);
    check("rst_vactive", int'(vActive), 1);
    check("rst_frameend", int'(FrameEnd), 0);
    check("rst_framecount", int'(FrameCount), 0);
    check("rst_paramerror", int'(ParamError), 0);
    @(negedge clock);
    reset = 1'b1;

    // Default frame 0..525; inputs change at line 100 but must not matter yet.
    walk_frame(480, 10, 2, 33, 100);

    for (int r = 0; r < 8; r++) begin
      set_inputs(recs[r].a, recs[r].f, recs[r].s, recs[r].b);
      do_wrap(recs[r].eperr);
      walk_frame(recs[r].ea, recs[r].ef, recs[r].es, recs[r].eb, -1);
    end

    // Extra wrap to line 0, then a LineEnd held for 7 clocks.
    set_inputs(4, 1, 1, 2);
    do_wrap(1);
    @(negedge clock);
    LineEnd = 1'b1;
    @(negedge clock);
    check("held_first_edge", int'(yposition), 1);
    repeat (6) @(negedge clock);
    check("held_7clk", int'(yposition), 1);
    LineEnd = 1'b0;
    repeat (3) @(negedge clock);
    check("held_after_drop", int'(yposition), 1);

    // Asynchronous reset while LineEnd is high.
    LineEnd = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("arst_y", int'(yposition), 0);
    check("arst_vsync", int'(vsync), 1);
    check("arst_vactive", int'(vActive), 1);
    check("arst_framecount", int'(FrameCount), 0);
    check("arst_paramerror", int'(ParamError), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("held_at_release_y", int'(yposition), 0);
    LineEnd = 1'b0;
    @(negedge clock);
    tick_line();
    check("first_tick_after_rst", int'(yposition), 1);

    // Default shadows restored: walk to 490 where vsync is low, then reset.
    for (int y = 2; y <= 490; y++) tick_line();
    check("pre_rst_y", int'(yposition), 490);
    check("pre_rst_vsync", int'(vsync), 0);
    check("pre_rst_vactive", int'(vActive), 0);
    #2 reset = 1'b0;
    #1;
    check("vsrst_y", int'(yposition), 0);
    check("vsrst_vsync", int'(vsync), 1);
    check("vsrst_vactive", int'(vActive), 1);
    @(negedge clock);
    reset = 1'b1;
    tick_line();
    check("vsrst_first_tick", int'(yposition), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
